// File: rtl/crc_engine.sv
// crc_engine: parametrised CRC accumulator with a start/ready/done handshake.
// Folds BITS_PER_CYCLE bits of a latched data word per clock using a
// run-time polynomial.
// Optional build macro: CRC_REFLECT_EN selects LSB-first folding and a
// bit-reversed crc_data_out. When it is undefined, folding is MSB-first and
// the output is the raw register.
module crc_engine #(
    parameter int CRC_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  crc_start,
    input  logic                  crc_reset,
    input  logic [DATA_WIDTH-1:0] crc_data_in,
    input  logic [CRC_WIDTH-1:0]  crc_seed,
    input  logic [CRC_WIDTH-1:0]  crc_poly,
    output logic                  crc_ready,
    output logic                  crc_done,
    output logic [CRC_WIDTH-1:0]  crc_data_out
);

    // Number of fold cycles per word, and the slice counter sized to hold N-1.
    localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state;
    logic [CRC_WIDTH-1:0]  r_crc;
    logic [CRC_WIDTH-1:0]  r_poly;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ready;
    logic                  r_done;

    // w_stage[k] is the CRC after k bits of the current slice have been folded.
    logic [CRC_WIDTH-1:0]      w_stage [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] w_bits;
    logic [DATA_WIDTH-1:0]     w_shift_next;

    assign w_stage[0] = r_crc;

    genvar gi;
    generate
`ifdef CRC_REFLECT_EN
        // LSB-first: the next slice sits at the bottom of the shift register.
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_bits_lsb
            assign w_bits[gi] = r_shift[gi];
        end
        assign w_shift_next = r_shift >> BITS_PER_CYCLE;
`else
        // MSB-first: the next slice sits at the top of the shift register.
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_bits_msb
            assign w_bits[gi] = r_shift[DATA_WIDTH-1-gi];
        end
        assign w_shift_next = r_shift << BITS_PER_CYCLE;
`endif

        // One LFSR step per data bit, chained combinationally within the cycle.
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_fold
            logic w_fb;
            assign w_fb = w_stage[gi][CRC_WIDTH-1] ^ w_bits[gi];
            assign w_stage[gi+1] = {w_stage[gi][CRC_WIDTH-2:0], 1'b0}
                                 ^ (w_fb ? r_poly : '0);
        end

`ifdef CRC_REFLECT_EN
        // The result is presented bit-reversed; the internal register stays unreflected.
        for (gi = 0; gi < CRC_WIDTH; gi++) begin : g_out_rev
            assign crc_data_out[gi] = r_crc[CRC_WIDTH-1-gi];
        end
`else
        assign crc_data_out = r_crc;
`endif
    endgenerate

    assign crc_ready = r_ready;
    assign crc_done  = r_done;

    // Handshake FSM: accept or seed in IDLE, fold one slice per cycle in BUSY.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_crc   <= '0;
            r_poly  <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    // A simultaneous seed load and start folds the word from the seed.
                    if (crc_reset) begin
                        r_crc <= crc_seed;
                    end
                    if (crc_start) begin
                        r_shift <= crc_data_in;
                        r_poly  <= crc_poly;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // Start and seed requests are ignored here, not queued.
                    r_crc   <= w_stage[BITS_PER_CYCLE];
                    r_shift <= w_shift_next;
                    if (r_cnt == LAST_SLICE) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: directed scoreboard bench for crc_engine.
// It runs a CRC-8 instance (8/8/1) and a CRC-16 instance (16/8/4).
module tb_crc_engine;

`ifdef CRC_REFLECT_EN
    localparam bit REFL = 1'b1;
`else
    localparam bit REFL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // CRC-8 instance signals
    logic        nrst8, start8, reset8, ready8, done8;
    logic [7:0]  data8, seed8, poly8, out8;
    // CRC-16 instance signals
    logic        nrst16, start16, reset16, ready16, done16;
    logic [7:0]  data16;
    logic [15:0] seed16, poly16, out16;

    crc_engine #(.CRC_WIDTH(8), .DATA_WIDTH(8), .BITS_PER_CYCLE(1)) u_crc8 (
        .CLK(clk), .nRST(nrst8), .crc_start(start8), .crc_reset(reset8),
        .crc_data_in(data8), .crc_seed(seed8), .crc_poly(poly8),
        .crc_ready(ready8), .crc_done(done8), .crc_data_out(out8)
    );

    crc_engine #(.CRC_WIDTH(16), .DATA_WIDTH(8), .BITS_PER_CYCLE(4)) u_crc16 (
        .CLK(clk), .nRST(nrst16), .crc_start(start16), .crc_reset(reset16),
        .crc_data_in(data16), .crc_seed(seed16), .crc_poly(poly16),
        .crc_ready(ready16), .crc_done(done16), .crc_data_out(out16)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] q8[$];
    logic [15:0] q16[$];
    logic [15:0] m8, m16;
    logic [7:0]  msg [0:8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bitwise reference CRC over one 8-bit word.
    function automatic logic [15:0] fold_model(input logic [15:0] crc, input logic [7:0] d,
                                               input logic [15:0] poly, input int w);
        logic [15:0] mask;
        logic        b, fb;
        mask = 16'((32'h1 << w) - 1);
        for (int i = 0; i < 8; i++) begin
            b   = REFL ? d[i] : d[7-i];
            fb  = crc[w-1] ^ b;
            crc = (crc << 1) & mask;
            if (fb) crc = crc ^ poly;
        end
        return crc;
    endfunction

    // Externally visible form of an internal register value.
    function automatic logic [15:0] disp(input logic [15:0] crc, input int w);
        logic [15:0] r;
        if (!REFL) return crc;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = crc[w-1-i];
        return r;
    endfunction

    // Drive a start (optionally with seed load) now and push the expected result.
    task automatic start_word(input int sel, input logic [7:0] d, input logic rst, input logic [15:0] seed);
        if (sel == 8) begin
            check("ready8_before_start", ready8, 1'b1);
            data8 = d; poly8 = 8'h07; seed8 = seed[7:0]; reset8 = rst; start8 = 1'b1;
            if (rst) m8 = seed & 16'h00FF;
            m8 = fold_model(m8, d, 16'h0007, 8);
            q8.push_back(disp(m8, 8));
            $display("push crc8  data=%02h seed_load=%0d exp=%02h", d, rst, disp(m8, 8));
        end else begin
            check("ready16_before_start", ready16, 1'b1);
            data16 = d; poly16 = 16'h1021; seed16 = seed; reset16 = rst; start16 = 1'b1;
            if (rst) m16 = seed;
            m16 = fold_model(m16, d, 16'h1021, 16);
            q16.push_back(disp(m16, 16));
            $display("push crc16 data=%02h seed_load=%0d exp=%04h", d, rst, disp(m16, 16));
        end
    endtask

    // Wait (bounded) for done, check latency and pop/compare the scoreboard.
    // disturb: pulse start/reset and scramble inputs while BUSY (CRC-8 only).
    task automatic wait_done(input int sel, input string tag, input bit disturb);
        int          cyc;
        bit          seen;
        logic [15:0] exp, obs;
        logic        rdy;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (sel == 8) begin start8 = 1'b0; reset8 = 1'b0; end
                else begin start16 = 1'b0; reset16 = 1'b0; end
            end
            if (disturb && cyc == 3) begin
                start8 = 1'b1; reset8 = 1'b1; data8 = 8'hFF; poly8 = 8'hAA; seed8 = 8'h5A;
            end
            if (disturb && cyc == 4) begin
                start8 = 1'b0; reset8 = 1'b0;
            end
            seen = (sel == 8) ? done8 : done16;
        end
        check({tag, "_latency"}, 64'(cyc), (sel == 8) ? 64'd9 : 64'd3);
        if (seen) begin
            if (sel == 8) begin
                exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
                obs = {8'h00, out8}; rdy = ready8;
            end else begin
                exp = (q16.size() > 0) ? q16.pop_front() : 16'hxxxx;
                obs = out16; rdy = ready16;
            end
            check(tag, obs, exp);
            check({tag, "_ready_in_done"}, rdy, 1'b1);
            $display("done %s cycles=%0d out=%04h exp=%04h", tag, cyc, obs, exp);
        end else begin
            $display("done %s timed out after %0d cycles", tag, cyc);
        end
    endtask

    logic [15:0] ref_ffff, ref_first;
    int          extra;

    initial begin
        msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34; msg[4] = 8'h35;
        msg[5] = 8'h36; msg[6] = 8'h37; msg[7] = 8'h38; msg[8] = 8'h39;
        nrst8 = 1'b0; start8 = 1'b0; reset8 = 1'b0; data8 = '0; seed8 = '0; poly8 = '0;
        nrst16 = 1'b0; start16 = 1'b0; reset16 = 1'b0; data16 = '0; seed16 = '0; poly16 = '0;
        m8 = '0; m16 = '0;

        ref_ffff = 16'hFFFF;
        for (int i = 0; i < 9; i++) ref_ffff = fold_model(ref_ffff, msg[i], 16'h1021, 16);
        ref_ffff  = disp(ref_ffff, 16);
        ref_first = disp(fold_model(16'h0000, msg[0], 16'h0007, 8), 8);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready8", ready8, 1'b1);
        check("rst_done8", done8, 1'b0);
        check("rst_out8", out8, 8'h00);
        check("rst_ready16", ready16, 1'b1);
        check("rst_done16", done16, 1'b0);
        check("rst_out16", out16, 16'h0000);
        nrst8 = 1'b1; nrst16 = 1'b1;
        @(negedge clk);

        // Seed load alone
        reset8 = 1'b1; seed8 = 8'h1E;
        @(negedge clk);
        reset8 = 1'b0;
        check("seed_load8", out8, disp(16'h001E, 8));
        reset8 = 1'b1; seed8 = 8'h00;
        @(negedge clk);
        reset8 = 1'b0;
        check("seed_zero8", out8, 8'h00);
        m8 = 16'h0000;

        // CRC-8 poly 0x07 seed 0 over "123456789"
        for (int i = 0; i < 9; i++) begin
            start_word(8, msg[i], 1'b0, 16'h0000);
            wait_done(8, "crc8", 1'b0);
            @(negedge clk);
            check("crc8_done_pulse", done8, 1'b0);
        end
`ifndef CRC_REFLECT_EN
        check("crc8_check_F4", out8, 8'hF4);
`endif

        // CRC-16 poly 0x1021 seed 0xFFFF
        reset16 = 1'b1; seed16 = 16'hFFFF;
        @(negedge clk);
        reset16 = 1'b0;
        check("seed_load16", out16, 16'hFFFF);
        m16 = 16'hFFFF;
        for (int i = 0; i < 9; i++) begin
            start_word(16, msg[i], 1'b0, 16'h0000);
            wait_done(16, "crc16_ffff", 1'b0);
            @(negedge clk);
        end
`ifndef CRC_REFLECT_EN
        check("crc16_check_29B1", out16, 16'h29B1);
`endif

        // CRC-16 seed 0x0000
        reset16 = 1'b1; seed16 = 16'h0000;
        @(negedge clk);
        reset16 = 1'b0;
        m16 = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            start_word(16, msg[i], 1'b0, 16'h0000);
            wait_done(16, "crc16_zero", 1'b0);
            @(negedge clk);
        end
`ifdef CRC_REFLECT_EN
        check("crc16_kermit_2189", out16, 16'h2189);
`else
        check("crc16_check_31C3", out16, 16'h31C3);
`endif

        // Start and seed load together on the first word
        start_word(16, msg[0], 1'b1, 16'hFFFF);
        wait_done(16, "start_with_seed", 1'b0);
        @(negedge clk);
        for (int i = 1; i < 9; i++) begin
            start_word(16, msg[i], 1'b0, 16'h0000);
            wait_done(16, "start_with_seed", 1'b0);
            @(negedge clk);
        end
        check("start_with_seed_result", out16, ref_ffff);

        // Back-to-back: each start is driven in the done cycle
        start_word(16, msg[0], 1'b1, 16'h0000);
        wait_done(16, "b2b", 1'b0);
        for (int i = 1; i < 9; i++) begin
            start_word(16, msg[i], 1'b0, 16'h0000);
            wait_done(16, "b2b", 1'b0);
        end
        @(negedge clk);
`ifdef CRC_REFLECT_EN
        check("b2b_result", out16, 16'h2189);
`else
        check("b2b_result", out16, 16'h31C3);
`endif

        // Start/reset pulses and input changes while BUSY are ignored
        start_word(8, 8'hC3, 1'b1, 16'h0000);
        wait_done(8, "busy_ignore", 1'b1);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) extra++;
        end
        check("busy_ignore_extra_done", 64'(extra), 64'd0);

        // Asynchronous reset mid-fold
        start_word(8, 8'h5C, 1'b1, 16'h0000);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin start8 = 1'b0; reset8 = 1'b0; end
        end
        nrst8 = 1'b0;
        #1;
        check("midrst_ready", ready8, 1'b1);
        check("midrst_done", done8, 1'b0);
        check("midrst_out", out8, 8'h00);
        void'(q8.pop_back());
        m8 = 16'h0000;
        @(negedge clk);
        nrst8 = 1'b1;
        @(negedge clk);
        start_word(8, msg[0], 1'b1, 16'h0000);
        wait_done(8, "after_midrst", 1'b0);
        check("after_midrst_fresh", out8, ref_first[7:0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised CRC engine, next generation of the single-bit CRC32 block. It accumulates a CRC of configurable width over a stream of data words. Each word is consumed at a configurable number of bits per clock, using a run-time programmable polynomial and seed. It sits between a word-wide producer (packet/bus datapath) and any consumer of the running checksum, and uses a start/ready/done handshake.

## Interface
- `CRC_WIDTH`, 32: width of CRC register, polynomial and seed (4..64).
- `DATA_WIDTH`, 32: width of each input word (8..64).
- `BITS_PER_CYCLE`, 1: bits folded per clock. Must divide `DATA_WIDTH`. Legal values are 1, 2, 4 and 8.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `crc_start` in 1: request to fold `crc_data_in` into the CRC. Accepted only when `crc_ready`=1.
- `crc_reset` in 1: load `crc_seed` into the CRC register. Honoured only when `crc_ready`=1.
- `crc_data_in` in `DATA_WIDTH`: data word, sampled on the accepting edge.
- `crc_seed` in `CRC_WIDTH`: initial CRC value.
- `crc_poly` in `CRC_WIDTH`: generator polynomial, implicit top term omitted (e.g. 0x04C11DB7). Sampled on the accepting edge.
- `crc_ready` out 1: engine idle, able to accept start or reset.
- `crc_done` out 1: one-cycle pulse; `crc_data_out` holds the result for the just-finished word.
- `crc_data_out` out `CRC_WIDTH`: current CRC value, registered.

## Operation
- State machine has two states, IDLE and BUSY. Reset state is IDLE.
- Reset values: `crc_ready`=1, `crc_done`=0, `crc_data_out`=0.
- IDLE, `crc_start`=1: latch `crc_data_in` into the shift register, latch `crc_poly`, clear the slice counter, go to BUSY.
- IDLE, `crc_reset`=1 with `crc_start`=0: CRC register ← `crc_seed`. Stay in IDLE.
- IDLE, `crc_reset`=1 with `crc_start`=1: CRC register ← `crc_seed` and the word is accepted. Folding of that word starts from the seed.
- BUSY: each cycle, fold `BITS_PER_CYCLE` bits, MSB of the word first. Each folded bit b does:
  - fb = crc[MSB] ^ b
  - crc = {crc[CRC_WIDTH-2:0],0} ^ (fb ? poly : 0)
  - These steps are chained combinationally within the cycle.
- The data shift register shifts left by `BITS_PER_CYCLE` after each fold.
- After `N = DATA_WIDTH/BITS_PER_CYCLE` folds, return to IDLE and assert `crc_done` for one cycle.
- `crc_start` and `crc_reset` while BUSY are ignored: not queued, no effect on state.
- Between words the CRC register holds its value, so a multi-word message accumulates until the next `crc_reset`.
- `crc_data_in`, `crc_poly` and `crc_seed` may change freely while BUSY. The latched copies are used.

## Timing
- Edge E0 accepts the start. Folds happen on edges E1..EN.
- `crc_ready` is 0 from after E0 until after EN.
- `crc_done` is 1 for exactly the cycle following EN. `crc_ready` is 1 in that same cycle.
- Back-to-back operation: a start may be accepted in the `crc_done` cycle, giving a throughput of one word per N+1 cycles.
- `crc_data_out` shows intermediate values on E1..EN-1. It is valid for the word only when `crc_done`=1, and holds until the next reset or fold.
- A seed load takes effect on the edge where `crc_reset` is sampled and is visible the next cycle.
- `nRST` asserted mid-BUSY: immediate return to IDLE with all reset values. The partial word is discarded.

## Configuration
- `CRC_REFLECT_EN` defined:
  - Each word is folded LSB first.
  - `crc_data_out` presents the internal register bit-reversed.
  - Seed and polynomial are still applied unreflected to the internal register.
  - Reset value of `crc_data_out` remains 0.
- `CRC_REFLECT_EN` undefined: MSB-first folding, `crc_data_out` equals the internal register. No reflection logic is synthesised.

## Test plan
- **CRC-8, poly 0x07, seed 0x00.** Configuration: `CRC_WIDTH`=8, `DATA_WIDTH`=8, `BITS_PER_CYCLE`=1. Feed ASCII "123456789" as 9 words → `crc_data_out`=0xF4 at the final `crc_done`. Each word must take exactly 9 cycles from start to done.
- **CRC-16/CCITT-FALSE, poly 0x1021, seed 0xFFFF.** Configuration: `CRC_WIDTH`=16, `DATA_WIDTH`=8, `BITS_PER_CYCLE`=4. Feed "123456789" → 0x29B1. Repeat with seed 0x0000 → 0x31C3. Each word takes 2 fold cycles.
- **CRC-16/KERMIT (`CRC_REFLECT_EN`).** Poly 0x1021, seed 0x0000, `DATA_WIDTH`=8. Feed "123456789" → 0x2189.
- **Handshake.**
  - Assert `crc_start` and `crc_reset` together in IDLE, seed 0xFFFF: the result must equal the seeded result.
  - Pulse `crc_start` and `crc_reset` mid-BUSY: no effect, `crc_done` count unchanged.
  - Issue a start in the `crc_done` cycle: it must be accepted.
- **Reset mid-operation.** Drop `nRST` on fold 3 of 8 → `crc_ready`=1, `crc_done`=0, `crc_data_out`=0 immediately. A subsequent word from seed 0 yields the same value as on a fresh run.
